// File: rtl/ram_burst_reader_1024x32.sv
// Burst read engine for a 1024x32 RAM port with a registered read address.
// Streams len consecutive words (wrapping at the top of memory) through a 2-entry skid FIFO.
module ram_burst_reader_1024x32 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   remain_reg, remain_next;
    logic              done_reg, done_next;
    logic              inflight_reg, inflight_last_reg;
    logic [1:0]        occ_reg;
    logic              wr_ptr_reg, rd_ptr_reg;

    logic [DATA_W-1:0] entry_data [2];
    logic              entry_last [2];

    logic pop;
    logic push;
    logic accept;
    logic credit_ok;
    logic issue;

    assign m_valid  = (occ_reg != 2'd0);
    assign m_data   = entry_data[rd_ptr_reg];
    assign m_last   = entry_last[rd_ptr_reg];
    assign pop      = m_valid & m_ready;
    assign push     = inflight_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    // The issue pointer doubles as the RAM address register.
    assign ram_addr = ptr_reg;

    // A slot is free when buffered + in-flight words leave room, counting a pop this cycle.
    assign credit_ok = ({1'b0, occ_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
    assign issue     = (state_reg == RUN) && credit_ok;
    // The done cycle itself is excluded so a new command starts the cycle after done.
    assign accept    = (state_reg == IDLE) && start && !done_reg;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        remain_next = remain_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (len != '0) begin
                        state_next  = RUN;
                        ptr_next    = start_addr;
                        remain_next = len;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    ptr_next    = ptr_reg + ADDR_W'(1);
                    remain_next = remain_reg - (ADDR_W+1)'(1);
                    if (remain_reg == (ADDR_W+1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            ptr_reg           <= '0;
            remain_reg        <= '0;
            done_reg          <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            occ_reg           <= 2'd0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            ptr_reg           <= ptr_next;
            remain_reg        <= remain_next;
            done_reg          <= done_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (remain_reg == (ADDR_W+1)'(1));
            occ_reg           <= occ_reg + {1'b0, push} - {1'b0, pop};
            wr_ptr_reg        <= wr_ptr_reg ^ push;
            rd_ptr_reg        <= rd_ptr_reg ^ pop;
        end
    end

    // Skid FIFO storage: the RAM word returns one cycle after its address was captured.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
            logic [DATA_W-1:0] data_reg;
            logic              last_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= ram_dout;
                    last_reg <= inflight_last_reg;
                end
            end

            assign entry_data[gi] = data_reg;
            assign entry_last[gi] = last_reg;
        end
    endgenerate

endmodule
